vend_ctrl_param: RTL and testbench

VEND_CTRL_PARAM -- requirements
Module: vend_ctrl_param

---
 rtl/vend_pkg.sv | 20 ++
 rtl/vend_change_gen.sv | 31 +++
 rtl/vend_ctrl_param.sv | 152 +++++++++++++++
 tb/tb_vend_ctrl_param.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared constants for the vending controller: coin values, FSM states and
// one-hot change-coin encodings ({nickel, dime, quarter}).
package vend_pkg;

    localparam int COIN_NICKEL  = 5;
    localparam int COIN_DIME    = 10;
    localparam int COIN_QUARTER = 25;

    localparam logic [2:0] CHG_NONE    = 3'b000;
    localparam logic [2:0] CHG_NICKEL  = 3'b100;
    localparam logic [2:0] CHG_DIME    = 3'b010;
    localparam logic [2:0] CHG_QUARTER = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_CHANGE   = 2'd2
    } vend_state_e;

endpackage

// File: rtl/vend_change_gen.sv
// Combinational greedy change picker: selects the largest coin not exceeding
// the remaining credit and reports its one-hot code and value.
module vend_change_gen #(
    parameter int CREDIT_W = 7
) (
    input  logic [CREDIT_W-1:0] i_credit,
    output logic [2:0]          o_coin,
    output logic [CREDIT_W-1:0] o_value
);
    import vend_pkg::*;

    localparam logic [CREDIT_W-1:0] LP_Q = CREDIT_W'(COIN_QUARTER);
    localparam logic [CREDIT_W-1:0] LP_D = CREDIT_W'(COIN_DIME);
    localparam logic [CREDIT_W-1:0] LP_N = CREDIT_W'(COIN_NICKEL);

    always_comb begin
        o_coin  = CHG_NONE;
        o_value = '0;
        if (i_credit >= LP_Q) begin
            o_coin  = CHG_QUARTER;
            o_value = LP_Q;
        end else if (i_credit >= LP_D) begin
            o_coin  = CHG_DIME;
            o_value = LP_D;
        end else if (i_credit >= LP_N) begin
            o_coin  = CHG_NICKEL;
            o_value = LP_N;
        end
    end

endmodule

// File: rtl/vend_ctrl_param.sv
// Parameterised vending controller: coin credit, product select, greedy change.
// Define VEND_CANCEL_EN to enable the i_cancel full-credit refund.
module vend_ctrl_param #(
    parameter int PRICE      = 20,
    parameter int N_PROD     = 4,
    parameter int MAX_CREDIT = 95,
    parameter int CREDIT_W   = 7
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst_n,
    input  logic                                        i_nickle,
    input  logic                                        i_dime,
    input  logic                                        i_quarter,
    input  logic [$clog2(N_PROD > 1 ? N_PROD : 2)-1:0]  i_sel,
    input  logic                                        i_sel_valid,
    input  logic [N_PROD-1:0]                           i_sold_out,
    input  logic                                        i_cancel,
    output logic [N_PROD-1:0]                           o_dispense,
    output logic [2:0]                                  o_change,
    output logic [CREDIT_W-1:0]                         o_credit,
    output logic                                        o_reject,
    output logic                                        o_busy
);
    import vend_pkg::*;

    localparam int SEL_W = $clog2(N_PROD > 1 ? N_PROD : 2);
    localparam logic [CREDIT_W:0]   LP_MAX   = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] LP_PRICE = CREDIT_W'(PRICE);
    localparam logic [SEL_W:0]      LP_NPROD = (SEL_W+1)'(N_PROD);

    vend_state_e         r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [N_PROD-1:0]   r_dispense;
    logic [2:0]          r_change;
    logic                r_reject;
    logic                r_busy;

    logic [1:0]          w_coin_cnt;
    logic                w_coin_any;
    logic                w_coin_multi;
    logic [CREDIT_W:0]   w_coin_val;
    logic [CREDIT_W:0]   w_sum;
    logic                w_coin_ok;
    logic                w_sel_ok;
    logic                w_cancel;
    logic [2:0]          w_chg_coin;
    logic [CREDIT_W-1:0] w_chg_val;
    logic [CREDIT_W-1:0] w_chg_rem;

    assign w_coin_cnt   = 2'(i_nickle) + 2'(i_dime) + 2'(i_quarter);
    assign w_coin_any   = (w_coin_cnt != 2'd0);
    assign w_coin_multi = (w_coin_cnt > 2'd1);

    always_comb begin
        w_coin_val = '0;
        if (i_quarter)
            w_coin_val = (CREDIT_W+1)'(COIN_QUARTER);
        else if (i_dime)
            w_coin_val = (CREDIT_W+1)'(COIN_DIME);
        else if (i_nickle)
            w_coin_val = (CREDIT_W+1)'(COIN_NICKEL);
    end

    // One extra bit so an over-ceiling sum cannot wrap back under MAX_CREDIT.
    assign w_sum     = {1'b0, r_credit} + w_coin_val;
    assign w_coin_ok = w_coin_any && !w_coin_multi && (w_sum <= LP_MAX);

    assign w_sel_ok = i_sel_valid
                   && ({1'b0, i_sel} < LP_NPROD)
                   && !i_sold_out[i_sel]
                   && (r_credit >= LP_PRICE);

`ifdef VEND_CANCEL_EN
    assign w_cancel = i_cancel && (r_credit != '0);
`else
    logic w_unused_cancel;
    assign w_unused_cancel = i_cancel;
    assign w_cancel        = 1'b0;
`endif

    vend_change_gen #(
        .CREDIT_W (CREDIT_W)
    ) u_change_gen (
        .i_credit (r_credit),
        .o_coin   (w_chg_coin),
        .o_value  (w_chg_val)
    );

    assign w_chg_rem = r_credit - w_chg_val;

    // Any coin strobe is returned unless IDLE accepts it as the sole credit event.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_credit   <= '0;
            r_dispense <= '0;
            r_change   <= CHG_NONE;
            r_reject   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_dispense <= '0;
            r_change   <= CHG_NONE;
            r_reject   <= w_coin_any;
            case (r_state)
                ST_IDLE: begin
                    if (w_cancel) begin
                        r_state <= ST_CHANGE;
                        r_busy  <= 1'b1;
                    end else if (w_sel_ok) begin
                        r_dispense <= N_PROD'(1) << i_sel;
                        r_credit   <= r_credit - LP_PRICE;
                        r_state    <= ST_DISPENSE;
                        r_busy     <= 1'b1;
                    end else if (w_coin_ok) begin
                        r_credit <= w_sum[CREDIT_W-1:0];
                        r_reject <= 1'b0;
                    end
                end
                ST_DISPENSE: begin
                    if (r_credit != '0) begin
                        r_state <= ST_CHANGE;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_CHANGE: begin
                    r_change <= w_chg_coin;
                    // A residue below a nickel cannot be paid out; drop it rather than stall.
                    if (w_chg_coin == CHG_NONE || w_chg_rem == '0) begin
                        r_credit <= '0;
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                    end else begin
                        r_credit <= w_chg_rem;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_dispense = r_dispense;
    assign o_change   = r_change;
    assign o_credit   = r_credit;
    assign o_reject   = r_reject;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Scoreboard bench for vend_ctrl_param (PRICE=20, N_PROD=4, MAX_CREDIT=95);
// cancel expectations follow VEND_CANCEL_EN.
module tb_vend_ctrl_param;

    typedef struct packed {
        logic       rst_n;
        logic [2:0] coin;     // {nickel, dime, quarter}
        logic       sv;
        logic [1:0] sel;
        logic [3:0] sold;
        logic       can;
    } stim_t;

    typedef struct packed {
        logic [3:0] disp;
        logic [2:0] chg;
        logic [6:0] cr;
        logic       rej;
        logic       busy;
    } obs_t;

    localparam logic [2:0] C0 = 3'b000;
    localparam logic [2:0] CN = 3'b100;
    localparam logic [2:0] CD = 3'b010;
    localparam logic [2:0] CQ = 3'b001;

    logic       clk = 1'b0;
    logic       rst_n, nickle, dime, quarter, sel_valid, cancel;
    logic [1:0] sel;
    logic [3:0] sold_out;
    logic [3:0] dispense;
    logic [2:0] change;
    logic [6:0] credit;
    logic       reject, busy;

    int   total = 0;
    int   bad   = 0;
    stim_t st_q[$];
    obs_t  ex_q[$];
    obs_t  sb[$];

    vend_ctrl_param #(
        .PRICE(20), .N_PROD(4), .MAX_CREDIT(95), .CREDIT_W(7)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_nickle    (nickle),
        .i_dime      (dime),
        .i_quarter   (quarter),
        .i_sel       (sel),
        .i_sel_valid (sel_valid),
        .i_sold_out  (sold_out),
        .i_cancel    (cancel),
        .o_dispense  (dispense),
        .o_change    (change),
        .o_credit    (credit),
        .o_reject    (reject),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic stim_t S(input logic [2:0] coin, input logic sv, input logic [1:0] s,
                                input logic [3:0] sold, input logic can, input logic rn);
        stim_t r;
        r.rst_n = rn; r.coin = coin; r.sv = sv; r.sel = s; r.sold = sold; r.can = can;
        return r;
    endfunction

    function automatic obs_t E(input logic [3:0] d, input logic [2:0] c, input logic [6:0] cr,
                               input logic rj, input logic b);
        obs_t r;
        r.disp = d; r.chg = c; r.cr = cr; r.rej = rj; r.busy = b;
        return r;
    endfunction

    function automatic obs_t sample();
        return {dispense, change, credit, reject, busy};
    endfunction

    task automatic apply(input stim_t s);
        rst_n     = s.rst_n;
        {nickle, dime, quarter} = s.coin;
        sel_valid = s.sv;
        sel       = s.sel;
        sold_out  = s.sold;
        cancel    = s.can;
    endtask

    task automatic add(input stim_t s, input obs_t e);
        st_q.push_back(s);
        ex_q.push_back(e);
    endtask

    task automatic do_reset();
        apply(S(C0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        apply(S(C0, 0, 0, 0, 0, 1));
    endtask

    task automatic test_reset();
        obs_t got, want;
        add(S(CQ, 1, 2, 0, 0, 0), E(0, 0, 0, 0, 0));
        add(S(CD, 0, 0, 0, 1, 0), E(0, 0, 0, 0, 0));
        add(S(C0, 0, 0, 0, 0, 1), E(0, 0, 0, 0, 0));
        while (st_q.size() > 0) begin
            apply(st_q.pop_front());
            sb.push_back(ex_q.pop_front());
            @(posedge clk); #1;
            want = sb.pop_front(); got = sample(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset: got disp=%b chg=%b credit=%0d rej=%b busy=%b want disp=%b chg=%b credit=%0d rej=%b busy=%b",
                         got.disp, got.chg, got.cr, got.rej, got.busy, want.disp, want.chg, want.cr, want.rej, want.busy);
            end
        end
    endtask

    task automatic test_purchase_dime_change();
        obs_t got, want;
        do_reset();
        add(S(CN, 0, 0, 0, 0, 1), E(0, 0, 5, 0, 0));
        add(S(CN, 0, 0, 0, 0, 1), E(0, 0, 10, 0, 0));
        add(S(CN, 0, 0, 0, 0, 1), E(0, 0, 15, 0, 0));
        add(S(CN, 0, 0, 0, 0, 1), E(0, 0, 20, 0, 0));
        add(S(CD, 0, 0, 0, 0, 1), E(0, 0, 30, 0, 0));
        add(S(C0, 1, 0, 0, 0, 1), E(4'b0001, 0, 10, 0, 1));
        add(S(C0, 0, 0, 0, 0, 1), E(0, 0, 10, 0, 1));
        add(S(C0, 0, 0, 0, 0, 1), E(0, CD, 0, 0, 0));
        add(S(C0, 0, 0, 0, 0, 1), E(0, 0, 0, 0, 0));
        while (st_q.size() > 0) begin
            apply(st_q.pop_front());
            sb.push_back(ex_q.pop_front());
            @(posedge clk); #1;
            want = sb.pop_front(); got = sample(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL purchase_dime: got disp=%b chg=%b credit=%0d rej=%b busy=%b want disp=%b chg=%b credit=%0d rej=%b busy=%b",
                         got.disp, got.chg, got.cr, got.rej, got.busy, want.disp, want.chg, want.cr, want.rej, want.busy);
            end
        end
    endtask

    task automatic test_nickel_change_busy_coin();
        obs_t got, want;
        do_reset();
        add(S(CQ, 0, 0, 0, 0, 1), E(0, 0, 25, 0, 0));
        add(S(C0, 1, 2, 0, 0, 1), E(4'b0100, 0, 5, 0, 1));
        add(S(CD, 0, 0, 0, 0, 1), E(0, 0, 5, 1, 1));
        add(S(C0, 0, 0, 0, 0, 1), E(0, CN, 0, 0, 0));
        add(S(C0, 0, 0, 0, 0, 1), E(0, 0, 0, 0, 0));
        while (st_q.size() > 0) begin
            apply(st_q.pop_front());
            sb.push_back(ex_q.pop_front());
            @(posedge clk); #1;
            want = sb.pop_front(); got = sample(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL nickel_change: got disp=%b chg=%b credit=%0d rej=%b busy=%b want disp=%b chg=%b credit=%0d rej=%b busy=%b",
                         got.disp, got.chg, got.cr, got.rej, got.busy, want.disp, want.chg, want.cr, want.rej, want.busy);
            end
        end
    endtask

    task automatic test_overflow_multi_coin();
        obs_t got, want;
        do_reset();
        add(S(CQ, 0, 0, 0, 0, 1), E(0, 0, 25, 0, 0));
        add(S(CQ, 0, 0, 0, 0, 1), E(0, 0, 50, 0, 0));
        add(S(CQ, 0, 0, 0, 0, 1), E(0, 0, 75, 0, 0));
        add(S(CD, 0, 0, 0, 0, 1), E(0, 0, 85, 0, 0));
        add(S(CN, 0, 0, 0, 0, 1), E(0, 0, 90, 0, 0));
        add(S(CQ, 0, 0, 0, 0, 1), E(0, 0, 90, 1, 0));
        add(S(CN | CD, 0, 0, 0, 0, 1), E(0, 0, 90, 1, 0));
        add(S(CN, 0, 0, 0, 0, 1), E(0, 0, 95, 0, 0));
        add(S(CN, 0, 0, 0, 0, 1), E(0, 0, 95, 1, 0));
        add(S(C0, 1, 0, 0, 0, 1), E(4'b0001, 0, 75, 0, 1));
        add(S(C0, 0, 0, 0, 0, 1), E(0, 0, 75, 0, 1));
        add(S(CD, 0, 0, 0, 0, 1), E(0, CQ, 50, 1, 1));
        add(S(C0, 0, 0, 0, 0, 1), E(0, CQ, 25, 0, 1));
        add(S(C0, 0, 0, 0, 0, 1), E(0, CQ, 0, 0, 0));
        while (st_q.size() > 0) begin
            apply(st_q.pop_front());
            sb.push_back(ex_q.pop_front());
            @(posedge clk); #1;
            want = sb.pop_front(); got = sample(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL overflow: got disp=%b chg=%b credit=%0d rej=%b busy=%b want disp=%b chg=%b credit=%0d rej=%b busy=%b",
                         got.disp, got.chg, got.cr, got.rej, got.busy, want.disp, want.chg, want.cr, want.rej, want.busy);
            end
        end
    endtask

    task automatic test_sel_ignored();
        obs_t got, want;
        do_reset();
        add(S(CD, 0, 0, 0, 0, 1), E(0, 0, 10, 0, 0));
        add(S(CN, 0, 0, 0, 0, 1), E(0, 0, 15, 0, 0));
        add(S(C0, 1, 1, 0, 0, 1), E(0, 0, 15, 0, 0));
        add(S(CN, 0, 0, 0, 0, 1), E(0, 0, 20, 0, 0));
        add(S(C0, 1, 1, 4'b0010, 0, 1), E(0, 0, 20, 0, 0));
        add(S(CN, 1, 1, 0, 0, 1), E(4'b0010, 0, 0, 1, 1));
        add(S(C0, 0, 0, 0, 0, 1), E(0, 0, 0, 0, 0));
        while (st_q.size() > 0) begin
            apply(st_q.pop_front());
            sb.push_back(ex_q.pop_front());
            @(posedge clk); #1;
            want = sb.pop_front(); got = sample(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL sel_ignored: got disp=%b chg=%b credit=%0d rej=%b busy=%b want disp=%b chg=%b credit=%0d rej=%b busy=%b",
                         got.disp, got.chg, got.cr, got.rej, got.busy, want.disp, want.chg, want.cr, want.rej, want.busy);
            end
        end
    endtask

    task automatic test_cancel();
        obs_t got, want;
        do_reset();
        add(S(CQ, 0, 0, 0, 0, 1), E(0, 0, 25, 0, 0));
        add(S(CD, 0, 0, 0, 0, 1), E(0, 0, 35, 0, 0));
        add(S(CD, 0, 0, 0, 0, 1), E(0, 0, 45, 0, 0));
`ifdef VEND_CANCEL_EN
        add(S(C0, 0, 0, 0, 1, 1), E(0, 0, 45, 0, 1));
        add(S(C0, 0, 0, 0, 0, 1), E(0, CQ, 20, 0, 1));
        add(S(C0, 0, 0, 0, 0, 1), E(0, CD, 10, 0, 1));
        add(S(C0, 0, 0, 0, 0, 1), E(0, CD, 0, 0, 0));
        add(S(CD, 0, 0, 0, 0, 1), E(0, 0, 10, 0, 0));
        add(S(CD, 0, 0, 0, 0, 1), E(0, 0, 20, 0, 0));
        add(S(C0, 1, 0, 0, 1, 1), E(0, 0, 20, 0, 1));
        add(S(C0, 0, 0, 0, 0, 1), E(0, CD, 10, 0, 1));
        add(S(C0, 0, 0, 0, 0, 1), E(0, CD, 0, 0, 0));
`else
        add(S(C0, 0, 0, 0, 1, 1), E(0, 0, 45, 0, 0));
        add(S(C0, 1, 0, 0, 0, 1), E(4'b0001, 0, 25, 0, 1));
        add(S(C0, 0, 0, 0, 0, 1), E(0, 0, 25, 0, 1));
        add(S(C0, 0, 0, 0, 0, 1), E(0, CQ, 0, 0, 0));
        add(S(CD, 0, 0, 0, 0, 1), E(0, 0, 10, 0, 0));
        add(S(CD, 0, 0, 0, 0, 1), E(0, 0, 20, 0, 0));
        add(S(C0, 1, 0, 0, 1, 1), E(4'b0001, 0, 0, 0, 1));
        add(S(C0, 0, 0, 0, 0, 1), E(0, 0, 0, 0, 0));
`endif
        while (st_q.size() > 0) begin
            apply(st_q.pop_front());
            sb.push_back(ex_q.pop_front());
            @(posedge clk); #1;
            want = sb.pop_front(); got = sample(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL cancel: got disp=%b chg=%b credit=%0d rej=%b busy=%b want disp=%b chg=%b credit=%0d rej=%b busy=%b",
                         got.disp, got.chg, got.cr, got.rej, got.busy, want.disp, want.chg, want.cr, want.rej, want.busy);
            end
        end
    endtask

    task automatic test_reset_mid_change();
        obs_t got, want;
        do_reset();
        add(S(CQ, 0, 0, 0, 0, 1), E(0, 0, 25, 0, 0));
        add(S(CQ, 0, 0, 0, 0, 1), E(0, 0, 50, 0, 0));
        add(S(CN, 0, 0, 0, 0, 1), E(0, 0, 55, 0, 0));
        add(S(C0, 1, 0, 0, 0, 1), E(4'b0001, 0, 35, 0, 1));
        add(S(C0, 0, 0, 0, 0, 1), E(0, 0, 35, 0, 1));
        add(S(C0, 0, 0, 0, 0, 0), E(0, 0, 0, 0, 0));
        add(S(C0, 0, 0, 0, 0, 1), E(0, 0, 0, 0, 0));
        add(S(C0, 0, 0, 0, 0, 1), E(0, 0, 0, 0, 0));
        while (st_q.size() > 0) begin
            apply(st_q.pop_front());
            sb.push_back(ex_q.pop_front());
            @(posedge clk); #1;
            want = sb.pop_front(); got = sample(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset_mid_change: got disp=%b chg=%b credit=%0d rej=%b busy=%b want disp=%b chg=%b credit=%0d rej=%b busy=%b",
                         got.disp, got.chg, got.cr, got.rej, got.busy, want.disp, want.chg, want.cr, want.rej, want.busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t got, want;
        do_reset();
        add(S(CQ, 0, 0, 0, 0, 1), E(0, 0, 25, 0, 0));
        add(S(CD, 0, 0, 0, 0, 1), E(0, 0, 35, 0, 0));
        add(S(CD, 0, 0, 0, 0, 1), E(0, 0, 45, 0, 0));
        add(S(C0, 1, 0, 0, 0, 1), E(4'b0001, 0, 25, 0, 1));
        add(S(C0, 1, 1, 0, 0, 1), E(0, 0, 25, 0, 1));
        add(S(C0, 0, 0, 0, 0, 1), E(0, CQ, 0, 0, 0));
        add(S(CD, 0, 0, 0, 0, 1), E(0, 0, 10, 0, 0));
        add(S(CD, 0, 0, 0, 0, 1), E(0, 0, 20, 0, 0));
        add(S(C0, 1, 3, 0, 0, 1), E(4'b1000, 0, 0, 0, 1));
        add(S(C0, 0, 0, 0, 0, 1), E(0, 0, 0, 0, 0));
        while (st_q.size() > 0) begin
            apply(st_q.pop_front());
            sb.push_back(ex_q.pop_front());
            @(posedge clk); #1;
            want = sb.pop_front(); got = sample(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL back_to_back: got disp=%b chg=%b credit=%0d rej=%b busy=%b want disp=%b chg=%b credit=%0d rej=%b busy=%b",
                         got.disp, got.chg, got.cr, got.rej, got.busy, want.disp, want.chg, want.cr, want.rej, want.busy);
            end
        end
    endtask

    initial begin
        apply(S(C0, 0, 0, 0, 0, 0));
        #2;
        test_reset();
        test_purchase_dime_change();
        test_nickel_change_busy_coin();
        test_overflow_multi_coin();
        test_sel_ignored();
        test_cancel();
        test_reset_mid_change();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
